dec_err_monitor: RTL and testbench

Output stage placed directly downstream of the 72-bit Hsiao DEC decoder/corrector (`dec_top`). It accepts each corrected 72-bit word together with its syndrome and error flags through a valid/ready handshake, and buffers the words in a 2-entry FIFO. It presents the 64 data bits downstream with a poison flag, and keeps saturating single/double error counters, a scrub request and a first-uncorrectable-error log.

---
 rtl/dec_err_monitor.sv | 187 ++++++++++++++++++
 tb/tb_dec_err_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_err_monitor.sv
// Output stage behind the Hsiao DEC corrector: 2-entry skid FIFO toward the consumer,
// plus saturating SGL/DBL counters, a sticky scrub request, IRQ and a first-DBL log.
module dec_err_monitor #(
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 32,
    parameter int THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [71:0]      IN_DATA,
    input  logic [7:0]       IN_SYN,
    input  logic             IN_ERR,
    input  logic             IN_SGL,
    input  logic             IN_DBL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [63:0]      OUT_DATA,
    output logic             OUT_POISON,
    output logic [CNT_W-1:0] SGL_CNT,
    output logic [CNT_W-1:0] DBL_CNT,
    output logic             SCRUB_REQ,
    output logic             IRQ,
    output logic             LOG_VALID,
    output logic             LOG_OVF,
    output logic [7:0]       LOG_SYN,
    output logic [IDX_W-1:0] LOG_IDX,
    input  logic             CLR
);

    localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(THRESH);

    typedef enum logic [1:0] {EV_NONE, EV_SGL, EV_DBL} ev_e;

    // FIFO storage and pointers
    logic [63:0]      r_mem_data [2];
    logic [1:0]       r_mem_psn;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Statistics and log
    logic [CNT_W-1:0] r_sgl_cnt;
    logic [CNT_W-1:0] r_dbl_cnt;
    logic             r_scrub;
    logic             r_irq;
    logic             r_log_valid;
    logic             r_log_ovf;
    logic [7:0]       r_log_syn;
    logic [IDX_W-1:0] r_log_idx;
    logic [IDX_W-1:0] r_idx;

    logic             w_push;
    logic             w_pop;
    ev_e              w_ev;
    logic [CNT_W-1:0] w_sgl_base;
    logic [CNT_W-1:0] w_dbl_base;
    logic [CNT_W-1:0] w_sgl_nxt;
    logic [CNT_W-1:0] w_dbl_nxt;
    logic             w_scrub_nxt;
    logic             w_irq_nxt;
    logic             w_log_valid_nxt;
    logic             w_log_ovf_nxt;
    logic [7:0]       w_log_syn_nxt;
    logic [IDX_W-1:0] w_log_idx_nxt;
    logic             w_unused;

    // Check bits and the bare ERR flag carry no information this stage needs.
    assign w_unused = &{1'b0, IN_ERR, IN_DATA[71:64]};

    assign IN_READY   = (r_count != 2'd2);
    assign OUT_VALID  = (r_count != 2'd0);
    assign OUT_DATA   = r_mem_data[r_rd_ptr];
    assign OUT_POISON = r_mem_psn[r_rd_ptr];
    assign w_push     = IN_VALID & IN_READY;
    assign w_pop      = OUT_VALID & OUT_READY;

    // NOTE: the two FIFO entries are reset on purpose so OUT_DATA/OUT_POISON read 0 out of reset;
    // larger memories would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_psn     <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= IN_DATA[63:0];
                r_mem_psn[r_wr_ptr]  <= IN_DBL;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // DBL dominates: the illegal SGL+DBL combination is classified as DBL.
    always_comb begin
        w_ev = EV_NONE;
        if (w_push && IN_DBL) begin
            w_ev = EV_DBL;
        end else if (w_push && IN_SGL) begin
            w_ev = EV_SGL;
        end
    end

    // CLR is applied first, then the accepted event lands on the cleared state.
    // NOTE: every output of this block is given a value up front, so no latch can be inferred.
    always_comb begin
        w_sgl_base      = CLR ? '0 : r_sgl_cnt;
        w_dbl_base      = CLR ? '0 : r_dbl_cnt;
        w_sgl_nxt       = w_sgl_base;
        w_dbl_nxt       = w_dbl_base;
        w_irq_nxt       = CLR ? 1'b0 : r_irq;
        w_log_valid_nxt = CLR ? 1'b0 : r_log_valid;
        w_log_ovf_nxt   = CLR ? 1'b0 : r_log_ovf;
        w_log_syn_nxt   = CLR ? 8'd0 : r_log_syn;
        w_log_idx_nxt   = CLR ? '0 : r_log_idx;

        if (w_ev == EV_SGL && w_sgl_base != '1) begin
            w_sgl_nxt = w_sgl_base + CNT_W'(1);
        end

        if (w_ev == EV_DBL) begin
            if (w_dbl_base != '1) begin
                w_dbl_nxt = w_dbl_base + CNT_W'(1);
            end
            w_irq_nxt = 1'b1;
            if (w_log_valid_nxt) begin
                w_log_ovf_nxt = 1'b1;
            end else begin
                w_log_valid_nxt = 1'b1;
                w_log_syn_nxt   = IN_SYN;
                w_log_idx_nxt   = r_idx;
            end
        end

        w_scrub_nxt = (CLR ? 1'b0 : r_scrub) | (w_sgl_nxt >= L_THRESH);
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sgl_cnt   <= '0;
            r_dbl_cnt   <= '0;
            r_scrub     <= 1'b0;
            r_irq       <= 1'b0;
            r_log_valid <= 1'b0;
            r_log_ovf   <= 1'b0;
            r_log_syn   <= 8'd0;
            r_log_idx   <= '0;
            r_idx       <= '0;
        end else begin
            r_sgl_cnt   <= w_sgl_nxt;
            r_dbl_cnt   <= w_dbl_nxt;
            r_scrub     <= w_scrub_nxt;
            r_irq       <= w_irq_nxt;
            r_log_valid <= w_log_valid_nxt;
            r_log_ovf   <= w_log_ovf_nxt;
            r_log_syn   <= w_log_syn_nxt;
            r_log_idx   <= w_log_idx_nxt;
            // The word index is untouched by CLR; it only tracks accepts.
            if (w_push) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign SGL_CNT   = r_sgl_cnt;
    assign DBL_CNT   = r_dbl_cnt;
    assign SCRUB_REQ = r_scrub;
    assign IRQ       = r_irq;
    assign LOG_VALID = r_log_valid;
    assign LOG_OVF   = r_log_ovf;
    assign LOG_SYN   = r_log_syn;
    assign LOG_IDX   = r_log_idx;

endmodule

// File: tb/tb_dec_err_monitor.sv
// Self-checking bench for dec_err_monitor: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the stage.
module tb_dec_err_monitor;

    localparam int CNT_W  = 16;
    localparam int IDX_W  = 32;
    localparam int THRESH = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [71:0]      IN_DATA = '0;
    logic [7:0]       IN_SYN = '0;
    logic             IN_ERR = 1'b0;
    logic             IN_SGL = 1'b0;
    logic             IN_DBL = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [63:0]      OUT_DATA;
    logic             OUT_POISON;
    logic [CNT_W-1:0] SGL_CNT;
    logic [CNT_W-1:0] DBL_CNT;
    logic             SCRUB_REQ;
    logic             IRQ;
    logic             LOG_VALID;
    logic             LOG_OVF;
    logic [7:0]       LOG_SYN;
    logic [IDX_W-1:0] LOG_IDX;
    logic             CLR = 1'b0;

    always #5 clk = ~clk;

    dec_err_monitor #(.CNT_W(CNT_W), .IDX_W(IDX_W), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_SYN(IN_SYN),
        .IN_ERR(IN_ERR), .IN_SGL(IN_SGL), .IN_DBL(IN_DBL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_POISON(OUT_POISON),
        .SGL_CNT(SGL_CNT), .DBL_CNT(DBL_CNT), .SCRUB_REQ(SCRUB_REQ), .IRQ(IRQ),
        .LOG_VALID(LOG_VALID), .LOG_OVF(LOG_OVF), .LOG_SYN(LOG_SYN), .LOG_IDX(LOG_IDX),
        .CLR(CLR)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: an ordered list of buffered words plus event bookkeeping.
    typedef struct {
        logic [63:0] d;
        logic        p;
    } ent_t;

    ent_t        m_q[$];
    int          m_sgl, m_dbl;
    bit          m_scrub, m_irq, m_lv, m_lo;
    logic [7:0]  m_lsyn;
    logic [31:0] m_lidx, m_idx;

    task automatic model_reset();
        m_q.delete();
        m_sgl = 0; m_dbl = 0;
        m_scrub = 0; m_irq = 0; m_lv = 0; m_lo = 0;
        m_lsyn = '0; m_lidx = '0; m_idx = '0;
    endtask

    task automatic compare_all();
        chk("in_ready",  IN_READY,  m_q.size() != 2);
        chk("out_valid", OUT_VALID, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("out_data",   OUT_DATA,   m_q[0].d);
            chk("out_poison", OUT_POISON, m_q[0].p);
        end
        chk("sgl_cnt",   SGL_CNT,   m_sgl);
        chk("dbl_cnt",   DBL_CNT,   m_dbl);
        chk("scrub_req", SCRUB_REQ, m_scrub);
        chk("irq",       IRQ,       m_irq);
        chk("log_valid", LOG_VALID, m_lv);
        chk("log_ovf",   LOG_OVF,   m_lo);
        chk("log_syn",   LOG_SYN,   m_lsyn);
        chk("log_idx",   LOG_IDX,   m_lidx);
    endtask

    // Advance one clock: update the model from the inputs as they stand, then compare.
    task automatic tick(input bit do_cmp);
        bit   acc, pop;
        ent_t e;
        acc = IN_VALID && (m_q.size() < 2);
        pop = OUT_READY && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e.d = IN_DATA[63:0];
            e.p = IN_DBL;
            m_q.push_back(e);
        end
        if (CLR) begin
            m_sgl = 0; m_dbl = 0; m_scrub = 0; m_irq = 0;
            m_lv = 0; m_lo = 0; m_lsyn = '0; m_lidx = '0;
        end
        if (acc && IN_DBL) begin
            m_dbl = (m_dbl < CMAX) ? m_dbl + 1 : CMAX;
            m_irq = 1;
            if (m_lv) m_lo = 1;
            else begin
                m_lv = 1; m_lsyn = IN_SYN; m_lidx = m_idx;
            end
        end else if (acc && IN_SGL) begin
            m_sgl = (m_sgl < CMAX) ? m_sgl + 1 : CMAX;
        end
        if (m_sgl >= THRESH) m_scrub = 1;
        if (acc) m_idx = m_idx + 1;
        @(posedge clk);
        #1;
        if (do_cmp) compare_all();
    endtask

    task automatic set_word(input logic [63:0] d, input logic [7:0] syn, input bit sgl, input bit dbl);
        IN_VALID = 1'b1;
        IN_DATA  = {8'($urandom), d};
        IN_SYN   = syn;
        IN_ERR   = sgl | dbl;
        IN_SGL   = sgl;
        IN_DBL   = dbl;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] syn, input bit sgl, input bit dbl);
        set_word(d, syn, sgl, dbl);
        tick(1);
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        IN_VALID = 1'b0;
        CLR = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] wa, wb, wc;

        // Reset state
        do_reset();
        compare_all();
        chk("rst_out_data",   OUT_DATA,   64'd0);
        chk("rst_out_poison", OUT_POISON, 1'b0);

        // Four clean words, one-cycle latency
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wa = {$urandom, $urandom};
            send(wa, 8'h00, 1'b0, 1'b0);
            chk("lat_valid", OUT_VALID, 1'b1);
            chk("lat_data",  OUT_DATA,  wa);
        end
        tick(1);

        // Backpressure: two accepted, third stalls, order preserved
        OUT_READY = 1'b0;
        wa = 64'hAAAA_0000_0000_0001;
        wb = 64'hBBBB_0000_0000_0002;
        wc = 64'hCCCC_0000_0000_0003;
        send(wa, 8'h00, 1'b0, 1'b0);
        send(wb, 8'h00, 1'b0, 1'b0);
        set_word(wc, 8'h00, 1'b0, 1'b0);
        chk("bp_full_ready", IN_READY, 1'b0);
        tick(1);
        chk("bp_hold_data", OUT_DATA, wa);
        OUT_READY = 1'b1;
        tick(1);
        chk("bp_second", OUT_DATA, wb);
        tick(1);
        IN_VALID = 1'b0;
        chk("bp_third", OUT_DATA, wc);
        tick(1);
        chk("bp_drained", OUT_VALID, 1'b0);

        // SGL threshold and saturation
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send({$urandom, $urandom}, 8'($urandom), 1'b1, 1'b0);
            chk("scrub_edge", SCRUB_REQ, i >= THRESH);
        end
        chk("sgl_eight", SGL_CNT, 16'd8);
        set_word(64'h1, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < (1 << CNT_W); i++) tick(0);
        IN_VALID = 1'b0;
        compare_all();
        chk("sgl_sat", SGL_CNT, 16'hFFFF);

        // First-DBL log with overflow
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
        send(64'h5555, 8'h0C, 1'b0, 1'b1);
        chk("dbl1_poison", OUT_POISON, 1'b1);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
        send(64'h9999, 8'h30, 1'b0, 1'b1);
        chk("dbl2_poison", OUT_POISON, 1'b1);
        chk("log_syn_first", LOG_SYN, 8'h0C);
        chk("log_idx_first", LOG_IDX, 32'd5);
        chk("log_ovf_set",   LOG_OVF, 1'b1);
        chk("dbl_two",       DBL_CNT, 16'd2);
        chk("irq_set",       IRQ,     1'b1);

        // CLR coinciding with a DBL accept
        send(64'h1234, 8'h11, 1'b1, 1'b0);
        CLR = 1'b1;
        send(64'hA0A0, 8'hA0, 1'b0, 1'b1);
        CLR = 1'b0;
        chk("clr_dbl_cnt", DBL_CNT,   16'd1);
        chk("clr_lv",      LOG_VALID, 1'b1);
        chk("clr_ovf",     LOG_OVF,   1'b0);
        chk("clr_syn",     LOG_SYN,   8'hA0);
        chk("clr_sgl",     SGL_CNT,   16'd0);

        // Asynchronous reset with two words buffered
        OUT_READY = 1'b0;
        send(64'h1, 8'h00, 1'b1, 1'b0);
        send(64'h2, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_out_valid", OUT_VALID, 1'b0);
        chk("arst_in_ready",  IN_READY,  1'b1);
        chk("arst_out_data",  OUT_DATA,  64'd0);
        chk("arst_dbl",       DBL_CNT,   16'd0);
        chk("arst_sgl",       SGL_CNT,   16'd0);
        chk("arst_irq",       IRQ,       1'b0);
        chk("arst_lv",        LOG_VALID, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        OUT_READY = 1'b1;
        send(64'h77, 8'h55, 1'b0, 1'b1);
        chk("arst_tag0", LOG_IDX, 32'd0);
        chk("arst_syn",  LOG_SYN, 8'h55);

        // Random traffic, including illegal SGL+DBL and occasional CLR
        for (int i = 0; i < 2000; i++) begin
            IN_VALID  = ($urandom_range(0, 9) < 7);
            IN_DATA   = {$urandom, $urandom, $urandom};
            IN_SYN    = 8'($urandom);
            IN_ERR    = 1'($urandom);
            IN_SGL    = ($urandom_range(0, 2) == 0);
            IN_DBL    = ($urandom_range(0, 9) == 0);
            OUT_READY = ($urandom_range(0, 9) < 6);
            CLR       = ($urandom_range(0, 99) < 3);
            tick(1);
        end
        IN_VALID = 1'b0;
        CLR = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
